// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the Wishbone timeout bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } wbb_state_e;

    localparam logic [31:0] ERR_DATA_DEF     = 32'hBADE_0E44;
    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_0B0B;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Saturating increment for the 16-bit fault counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Cycle counter for an outstanding slave request. Cleared when a request is
// accepted, counts while enabled and flags expiry on its final count.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, count holds at LAST so it can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone classic bridge from the EOS S3 fabric master to the
// LiteX slave port. Slave errors and hung cycles complete as a normal ack
// carrying a fixed fault word, since the master has no error input.
// Optional macro WBB_FAULT_STATUS_EN adds fault_cnt/last_fault_adr/last_fault_to.
module wb_timeout_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [16:0] m_adr,
    input  logic        m_cyc,
    input  logic        m_stb,
    input  logic        m_we,
    input  logic [3:0]  m_sel,
    input  logic [31:0] m_dat_w,
    output logic [31:0] m_dat_r,
    output logic        m_ack,
    output logic [14:0] s_adr,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_dat_w,
    output logic [2:0]  s_cti,
    output logic [1:0]  s_bte,
    input  logic [31:0] s_dat_r,
    input  logic        s_ack,
    input  logic        s_err
`ifdef WBB_FAULT_STATUS_EN
   ,output logic [15:0] fault_cnt,
    output logic [14:0] last_fault_adr,
    output logic        last_fault_to
`endif
);

    wbb_state_e  state_q, state_d;
    logic [14:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_w_q, dat_w_d;
    logic [31:0] dat_r_q, dat_r_d;
    logic        ctr_clr;
    logic        ctr_expire;

    // Byte-lane bits of the master address are dropped by the word conversion.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^m_adr[1:0];

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ctr (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .clr_i    (ctr_clr),
        .en_i     (state_q == REQ),
        .expire_o (ctr_expire)
    );

    // Next-state and capture logic. A master abort beats any slave response;
    // ack beats err, and both beat the timeout.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_w_d = dat_w_q;
        dat_r_d = dat_r_q;
        ctr_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    adr_d   = m_adr[16:2];
                    we_d    = m_we;
                    sel_d   = m_sel;
                    dat_w_d = m_dat_w;
                    ctr_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!m_cyc) begin
                    state_d = IDLE;
                end else if (s_ack) begin
                    dat_r_d = we_q ? 32'h0 : s_dat_r;
                    state_d = RESP;
                end else if (s_err) begin
                    dat_r_d = ERR_DATA;
                    state_d = RESP;
                end else if (ctr_expire) begin
                    dat_r_d = TIMEOUT_DATA;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request/response latches.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_w_q <= '0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_w_q <= dat_w_d;
            dat_r_q <= dat_r_d;
        end
    end

    assign s_cyc   = (state_q == REQ);
    assign s_stb   = (state_q == REQ);
    assign s_adr   = adr_q;
    assign s_we    = we_q;
    assign s_sel   = sel_q;
    assign s_dat_w = dat_w_q;
    assign s_cti   = CTI_CLASSIC;
    assign s_bte   = BTE_LINEAR;
    assign m_ack   = (state_q == RESP);
    assign m_dat_r = dat_r_q;

`ifdef WBB_FAULT_STATUS_EN
    logic [15:0] fault_cnt_q, fault_cnt_d;
    logic [14:0] last_fault_adr_q, last_fault_adr_d;
    logic        last_fault_to_q, last_fault_to_d;
    logic        fault_ev;

    // A fault completion is an err or timeout that actually reaches RESP.
    always_comb begin
        fault_ev         = (state_q == REQ) && m_cyc && !s_ack && (s_err || ctr_expire);
        fault_cnt_d      = fault_cnt_q;
        last_fault_adr_d = last_fault_adr_q;
        last_fault_to_d  = last_fault_to_q;
        if (fault_ev) begin
            fault_cnt_d      = sat_inc16(fault_cnt_q);
            last_fault_adr_d = adr_q;
            last_fault_to_d  = !s_err;
        end
    end

    // Fault status registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fault_cnt_q      <= '0;
            last_fault_adr_q <= '0;
            last_fault_to_q  <= 1'b0;
        end else begin
            fault_cnt_q      <= fault_cnt_d;
            last_fault_adr_q <= last_fault_adr_d;
            last_fault_to_q  <= last_fault_to_d;
        end
    end

    assign fault_cnt      = fault_cnt_q;
    assign last_fault_adr = last_fault_adr_q;
    assign last_fault_to  = last_fault_to_q;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed and randomised bench for wb_timeout_bridge (TIMEOUT_CYCLES = 16).
module tb_wb_timeout_bridge;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [16:0] m_adr;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_dat_w;
    logic [31:0] m_dat_r;
    logic        m_ack;
    logic [14:0] s_adr;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err;
`ifdef WBB_FAULT_STATUS_EN
    logic [15:0] fault_cnt;
    logic [14:0] last_fault_adr;
    logic        last_fault_to;
`endif

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_timeout_bridge #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_adr   (m_adr),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .s_adr   (s_adr),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_sel   (s_sel),
        .s_dat_w (s_dat_w),
        .s_cti   (s_cti),
        .s_bte   (s_bte),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .s_err   (s_err)
`ifdef WBB_FAULT_STATUS_EN
       ,.fault_cnt      (fault_cnt),
        .last_fault_adr (last_fault_adr),
        .last_fault_to  (last_fault_to)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, early, n_ack, m_acks, s_acks, wait_left, idx, got;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wd;

        sys_rst = 1'b1;
        m_adr = '0; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = '0; m_dat_w = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
        step();
        step();
        chk("rst_m_ack", m_ack, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_m_dat_r", m_dat_r, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_s_sel", s_sel, 0);
        chk("rst_s_dat_w", s_dat_w, 0);
        chk("rst_cti_bte", {s_cti, s_bte}, 0);
`ifdef WBB_FAULT_STATUS_EN
        chk("rst_fault", {fault_cnt, last_fault_adr, last_fault_to}, 0);
`endif
        sys_rst = 1'b0;
        step();

        // Read with slave ack three cycles after s_stb
        m_adr = 17'h0_0010; m_we = 0; m_sel = 4'hF; m_cyc = 1; m_stb = 1;
        step();
        chk("t1_s_stb", s_stb, 1);
        chk("t1_s_cyc", s_cyc, 1);
        chk("t1_s_adr", s_adr, 15'h0004);
        chk("t1_s_we", s_we, 0);
        n_ack = 0;
        repeat (3) begin step(); n_ack += int'(m_ack); end
        chk("t1_early_ack", n_ack, 0);
        chk("t1_s_stb_held", s_stb, 1);
        s_ack = 1; s_dat_r = 32'h1234_5678;
        step();
        chk("t1_m_ack", m_ack, 1);
        chk("t1_m_dat_r", m_dat_r, 32'h1234_5678);
        chk("t1_s_stb_low", s_stb, 0);
        s_ack = 0; s_dat_r = '0; m_cyc = 0; m_stb = 0;
        step();
        chk("t1_ack_once", m_ack, 0);
        chk("t1_dat_hold", m_dat_r, 32'h1234_5678);

        // Zero-wait write, top of address space
        m_adr = 17'h1_FFFC; m_we = 1; m_sel = 4'b0011; m_dat_w = 32'hCAFE_F00D;
        m_cyc = 1; m_stb = 1;
        step();
        chk("t2_s_we", s_we, 1);
        chk("t2_s_sel", s_sel, 4'b0011);
        chk("t2_s_dat_w", s_dat_w, 32'hCAFE_F00D);
        chk("t2_s_adr", s_adr, 15'h7FFF);
        s_ack = 1; s_dat_r = 32'h5555_AAAA;
        step();
        chk("t2_m_ack", m_ack, 1);
        chk("t2_wr_dat", m_dat_r, 32'h0);
        s_ack = 0; s_dat_r = '0; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 4'hF;
        step();

        // Slave error on a read
        m_adr = 17'h0_0100; m_cyc = 1; m_stb = 1;
        step();
        s_err = 1;
        step();
        chk("t3_m_ack", m_ack, 1);
        chk("t3_err_dat", m_dat_r, 32'hBADE_0E44);
`ifdef WBB_FAULT_STATUS_EN
        chk("t3_fault_cnt", fault_cnt, 1);
        chk("t3_fault_to", last_fault_to, 0);
        chk("t3_fault_adr", last_fault_adr, 15'h0040);
`endif
        s_err = 0; m_cyc = 0; m_stb = 0;
        step();

        // ack and err together: ack wins
        m_adr = 17'h0_0020; m_cyc = 1; m_stb = 1;
        step();
        s_ack = 1; s_err = 1; s_dat_r = 32'h7777_1111;
        step();
        chk("t3b_m_ack", m_ack, 1);
        chk("t3b_ack_wins", m_dat_r, 32'h7777_1111);
`ifdef WBB_FAULT_STATUS_EN
        chk("t3b_fault_cnt", fault_cnt, 1);
`endif
        s_ack = 0; s_err = 0; s_dat_r = '0; m_cyc = 0; m_stb = 0;
        step();

        // Silent slave: timeout after 16 strobe cycles
        m_adr = 17'h0_0200; m_cyc = 1; m_stb = 1;
        step();
        hi = 0; early = 0;
        repeat (16) begin hi += int'(s_stb); early += int'(m_ack); step(); end
        chk("t4_stb_cycles", hi, 16);
        chk("t4_early_ack", early, 0);
        chk("t4_s_stb_low", s_stb, 0);
        chk("t4_m_ack", m_ack, 1);
        chk("t4_to_dat", m_dat_r, 32'hDEAD_0B0B);
`ifdef WBB_FAULT_STATUS_EN
        chk("t4_fault_cnt", fault_cnt, 2);
        chk("t4_fault_to", last_fault_to, 1);
        chk("t4_fault_adr", last_fault_adr, 15'h0080);
`endif
        m_cyc = 0; m_stb = 0;
        step();

        // Ack on the 16th strobe cycle beats the timeout
        m_adr = 17'h0_0204; m_cyc = 1; m_stb = 1;
        step();
        hi = 0;
        repeat (15) begin hi += int'(s_stb); step(); end
        chk("t4b_s_stb_16th", s_stb, 1);
        s_ack = 1; s_dat_r = 32'hA5A5_5A5A;
        step();
        chk("t4b_m_ack", m_ack, 1);
        chk("t4b_ack_wins", m_dat_r, 32'hA5A5_5A5A);
`ifdef WBB_FAULT_STATUS_EN
        chk("t4b_fault_cnt", fault_cnt, 2);
`endif
        s_ack = 0; s_dat_r = '0; m_cyc = 0; m_stb = 0;
        step();

        // Master abort in REQ
        m_adr = 17'h0_0300; m_cyc = 1; m_stb = 1;
        step();
        chk("t5_s_cyc", s_cyc, 1);
        step();
        m_cyc = 0; m_stb = 0;
        step();
        chk("t5_abort_cyc", s_cyc, 0);
        chk("t5_abort_stb", s_stb, 0);
        n_ack = int'(m_ack);
        step();
        n_ack += int'(m_ack);
        chk("t5_abort_no_ack", n_ack, 0);
        chk("t5_abort_dat", m_dat_r, 32'hA5A5_5A5A);

        // Reset pulse in REQ
        m_adr = 17'h0_0400; m_cyc = 1; m_stb = 1;
        step();
        m_cyc = 0; m_stb = 0; sys_rst = 1;
        step();
        chk("t5_rst_cyc", s_cyc, 0);
        chk("t5_rst_stb", s_stb, 0);
        chk("t5_rst_ack", m_ack, 0);
        chk("t5_rst_adr", s_adr, 0);
        chk("t5_rst_dat", m_dat_r, 0);
        sys_rst = 0;
        step();
        chk("t5_rst_no_ack", m_ack, 0);

        // Normal read after abort/reset
        m_adr = 17'h0_0014; m_cyc = 1; m_stb = 1;
        step();
        chk("t5_after_adr", s_adr, 15'h0005);
        s_ack = 1; s_dat_r = 32'h0F0F_1234;
        step();
        chk("t5_after_ack", m_ack, 1);
        chk("t5_after_dat", m_dat_r, 32'h0F0F_1234);
        s_ack = 0; s_dat_r = '0; m_cyc = 0; m_stb = 0;
        step();

        // Random back-to-back traffic against a memory slave
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        m_acks = 0; s_acks = 0;
        for (int t = 0; t < 100; t++) begin
            idx = int'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(1, 15));
            wd  = $urandom;
            m_adr = 17'(idx * 4 + int'($urandom_range(0, 3)));
            m_we = we; m_sel = sel; m_dat_w = wd; m_cyc = 1; m_stb = 1;
            wait_left = int'($urandom_range(0, 5));
            got = 0;
            for (int c = 0; c < 40 && got == 0; c++) begin
                step();
                if (s_ack) begin
                    s_ack = 0;
                end else if (s_stb) begin
                    if (wait_left == 0) begin
                        s_ack = 1;
                        s_acks++;
                        if (s_we) slv_mem[s_adr[3:0]] = merge(slv_mem[s_adr[3:0]], s_dat_w, s_sel);
                        else      s_dat_r = slv_mem[s_adr[3:0]];
                    end else begin
                        wait_left--;
                    end
                end
                if (m_ack) begin
                    got = 1;
                    m_acks++;
                    if (we) begin
                        chk("rnd_wr_dat", m_dat_r, 32'h0);
                        ref_mem[idx] = merge(ref_mem[idx], wd, sel);
                    end else begin
                        chk("rnd_rd_dat", m_dat_r, ref_mem[idx]);
                    end
                    m_cyc = 0; m_stb = 0;
                end
            end
            chk("rnd_ack_seen", got, 1);
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
        step();
        chk("rnd_pairing", m_acks, s_acks);
        chk("rnd_m_acks", m_acks, 100);
        for (int i = 0; i < 16; i++) chk("rnd_mem_final", slv_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
